// File: rtl/success_latch_arbiter.sv
// rtl/success_latch_arbiter.sv - confirms controller done lines over consecutive cycles,
// latches the lowest-index winner until acknowledged, or reports a timeout.
module success_latch_arbiter #(
  parameter int NUM_CTRL       = 4,
  parameter int IDX_W          = $clog2(NUM_CTRL),
  parameter int CONFIRM_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                ack,
  input  logic [NUM_CTRL-1:0] controllerDone,
  output logic                busy,
  output logic                success,
  output logic [IDX_W-1:0]    successfulController,
  output logic                multiHit,
  output logic                timeout,
  output logic [CNT_W-1:0]    latency
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_FOUND, S_TMOUT} state_t;

  localparam logic [7:0]  CONF_M1 = 8'(CONFIRM_CYCLES - 1);
  localparam logic [31:0] TO_M1   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [32:0] LAT_MAX = (33'd1 << CNT_W) - 33'd1;

  state_t              state, state_nxt;
  logic [7:0]          run_cnt [NUM_CTRL];
  logic [31:0]         elapsed;
  logic [32:0]         elapsed_p1;
  logic [CNT_W-1:0]    lat_val;
  logic [NUM_CTRL-1:0] confirm;
  logic [IDX_W-1:0]    win_idx;
  logic [4:0]          n_hits;
  logic                arm;

  always_comb begin
    confirm = '0;
    for (int i = 0; i < NUM_CTRL; i++)
      confirm[i] = controllerDone[i] && (run_cnt[i] == CONF_M1);
  end

  // Descending scan so the lowest confirming index is the last one written.
  always_comb begin
    win_idx = '0;
    n_hits  = '0;
    for (int i = NUM_CTRL - 1; i >= 0; i--) begin
      if (confirm[i]) begin
        win_idx = IDX_W'(i);
        n_hits  = n_hits + 5'd1;
      end
    end
  end

  always_comb begin
    elapsed_p1 = {1'b0, elapsed} + 33'd1;
    lat_val    = (elapsed_p1 >= LAT_MAX) ? '1 : elapsed_p1[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    arm       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          arm       = 1'b1;
          state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (start)
          arm = 1'b1;
        else if (|confirm)
          state_nxt = S_FOUND;
        else if ((TIMEOUT_CYCLES != 0) && (elapsed == TO_M1))
          state_nxt = S_TMOUT;
      end
      S_FOUND, S_TMOUT: begin
        if (ack) begin
          if (start) begin
            arm       = 1'b1;
            state_nxt = S_ARMED;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy                 <= 1'b0;
      success              <= 1'b0;
      timeout              <= 1'b0;
      successfulController <= '0;
      multiHit             <= 1'b0;
      latency              <= '0;
      elapsed              <= '0;
      for (int i = 0; i < NUM_CTRL; i++) run_cnt[i] <= '0;
    end else begin
      busy    <= (state_nxt == S_ARMED);
      success <= (state_nxt == S_FOUND);
      timeout <= (state_nxt == S_TMOUT);
      if (arm) begin
        elapsed  <= '0;
        multiHit <= 1'b0;
        for (int i = 0; i < NUM_CTRL; i++) run_cnt[i] <= '0;
      end else if (state == S_ARMED) begin
        if (elapsed != '1) elapsed <= elapsed + 32'd1;
        for (int i = 0; i < NUM_CTRL; i++) begin
          if (!controllerDone[i])     run_cnt[i] <= '0;
          else if (run_cnt[i] != '1)  run_cnt[i] <= run_cnt[i] + 8'd1;
        end
        if (state_nxt == S_FOUND) begin
          successfulController <= win_idx;
          multiHit             <= (n_hits > 5'd1);
          latency              <= lat_val;
        end else if (state_nxt == S_TMOUT) begin
          successfulController <= '0;
          multiHit             <= 1'b0;
          latency              <= '1;
        end
      end
    end
  end

endmodule

// File: tb/tb_success_latch_arbiter.sv
// tb/tb_success_latch_arbiter.sv - two parameterisations checked every cycle against
// a run-length-by-position model, plus directed scenarios with literal expectations.
module tb_success_latch_arbiter;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       ack;
  logic [7:0] done;

  logic        a_busy, a_succ, a_mh, a_to;
  logic [2:0]  a_idx;
  logic [15:0] a_lat;
  logic        b_busy, b_succ, b_mh, b_to;
  logic [1:0]  b_idx;
  logic [2:0]  b_lat;

  success_latch_arbiter #(
    .NUM_CTRL(8), .IDX_W(3), .CONFIRM_CYCLES(2), .TIMEOUT_CYCLES(10), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .ack(ack), .controllerDone(done),
    .busy(a_busy), .success(a_succ), .successfulController(a_idx),
    .multiHit(a_mh), .timeout(a_to), .latency(a_lat)
  );

  success_latch_arbiter #(
    .NUM_CTRL(4), .IDX_W(2), .CONFIRM_CYCLES(3), .TIMEOUT_CYCLES(0), .CNT_W(3)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .ack(ack), .controllerDone(done[3:0]),
    .busy(b_busy), .success(b_succ), .successfulController(b_idx),
    .multiHit(b_mh), .timeout(b_to), .latency(b_lat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Model: 0 idle, 1 armed, 2 found, 3 timeout. A line confirms when the span since
  // its last low sample (position in the armed run) reaches the confirm length.
  int p_n[2]    = '{8, 4};
  int p_conf[2] = '{2, 3};
  int p_to[2]   = '{10, 0};
  int p_max[2]  = '{65535, 7};
  int m_state[2];
  int m_idx[2];
  int m_multi[2];
  int m_lat[2];
  int m_pos[2];
  int m_last_low[2][8];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    else passes++;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_idx[k] = 0; m_multi[k] = 0; m_lat[k] = 0; m_pos[k] = 0;
      for (int i = 0; i < 8; i++) m_last_low[k][i] = 0;
    end
  endtask

  task automatic model_arm(input int k);
    m_state[k] = 1;
    m_pos[k]   = 0;
    m_multi[k] = 0;
    for (int i = 0; i < 8; i++) m_last_low[k][i] = 0;
  endtask

  task automatic model_step(input int k);
    int hits;
    int first;
    case (m_state[k])
      0: if (start) model_arm(k);
      1: begin
        if (start) model_arm(k);
        else begin
          m_pos[k]++;
          hits  = 0;
          first = -1;
          for (int i = 0; i < p_n[k]; i++) begin
            if (done[i]) begin
              if (m_pos[k] - m_last_low[k][i] >= p_conf[k]) begin
                hits++;
                if (first < 0) first = i;
              end
            end else begin
              m_last_low[k][i] = m_pos[k];
            end
          end
          if (hits > 0) begin
            m_state[k] = 2;
            m_idx[k]   = first;
            m_multi[k] = (hits >= 2) ? 1 : 0;
            m_lat[k]   = (m_pos[k] > p_max[k]) ? p_max[k] : m_pos[k];
          end else if (p_to[k] != 0 && m_pos[k] == p_to[k]) begin
            m_state[k] = 3;
            m_idx[k]   = 0;
            m_multi[k] = 0;
            m_lat[k]   = p_max[k];
          end
        end
      end
      default: begin
        if (ack) begin
          if (start) model_arm(k);
          else m_state[k] = 0;
        end
      end
    endcase
  endtask

  task automatic compare_one(input int k, input int bsy, input int suc, input int tmo,
                             input int idx, input int mh, input int lat);
    chk($sformatf("dut%0d busy", k), bsy, (m_state[k] == 1) ? 1 : 0);
    chk($sformatf("dut%0d success", k), suc, (m_state[k] == 2) ? 1 : 0);
    chk($sformatf("dut%0d timeout", k), tmo, (m_state[k] == 3) ? 1 : 0);
    chk($sformatf("dut%0d multiHit", k), mh, m_multi[k]);
    if (m_state[k] != 1) begin
      chk($sformatf("dut%0d index", k), idx, m_idx[k]);
      chk($sformatf("dut%0d latency", k), lat, m_lat[k]);
    end
  endtask

  task automatic compare_all();
    compare_one(0, int'(a_busy), int'(a_succ), int'(a_to), int'(a_idx), int'(a_mh), int'(a_lat));
    compare_one(1, int'(b_busy), int'(b_succ), int'(b_to), int'(b_idx), int'(b_mh), int'(b_lat));
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    compare_all();
  endtask

  task automatic chk_a_zero(input string nm);
    chk({nm, " busy"}, int'(a_busy), 0);
    chk({nm, " success"}, int'(a_succ), 0);
    chk({nm, " timeout"}, int'(a_to), 0);
    chk({nm, " index"}, int'(a_idx), 0);
    chk({nm, " multiHit"}, int'(a_mh), 0);
    chk({nm, " latency"}, int'(a_lat), 0);
    chk({nm, " b latency"}, int'(b_lat), 0);
  endtask

  task automatic async_reset(input string nm);
    @(posedge clk);
    model_step(0);
    model_step(1);
    #2 rst_n = 1'b0;
    #1 chk_a_zero(nm);
    model_reset();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  task automatic arm();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic release_result();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  int mode;

  initial begin
    rst_n = 1'b0; start = 1'b0; ack = 1'b0; done = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    chk_a_zero("reset");
    rst_n = 1'b1;
    step();

    // Single line held from the arming edge: confirms two samples later.
    done = 8'h04; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("t1 early success", int'(a_succ), 0);
    step();
    chk("t1 success", int'(a_succ), 1);
    chk("t1 index", int'(a_idx), 2);
    chk("t1 multiHit", int'(a_mh), 0);
    chk("t1 latency", int'(a_lat), 2);
    repeat (3) step();
    chk("t1 b index", int'(b_idx), 2);
    chk("t1 b latency", int'(b_lat), 3);
    chk("t1 held index", int'(a_idx), 2);
    release_result();
    chk("t1 ack success", int'(a_succ), 0);
    chk("t1 ack busy", int'(a_busy), 0);
    chk("t1 idle index", int'(a_idx), 2);

    // Two simultaneous confirms.
    done = 8'h00;
    arm();
    done = 8'h0A;
    step();
    step();
    chk("t2 index", int'(a_idx), 1);
    chk("t2 multiHit", int'(a_mh), 1);
    step();
    chk("t2 b multiHit", int'(b_mh), 1);
    release_result();

    // Glitch on ch0, then ch3 held; toggling inputs in FOUND changes nothing.
    done = 8'h00;
    arm();
    done = 8'h01; step();
    done = 8'h00; step();
    done = 8'h08; step();
    chk("t3 glitch", int'(a_succ), 0);
    step();
    chk("t3 index", int'(a_idx), 3);
    chk("t3 latency", int'(a_lat), 4);
    for (int i = 0; i < 4; i++) begin
      done = 8'($urandom);
      step();
    end
    chk("t3 held index", int'(a_idx), 3);
    chk("t3 held latency", int'(a_lat), 4);
    release_result();

    // Timeout after exactly ten armed cycles.
    done = 8'h00;
    arm();
    for (int i = 1; i < 10; i++) step();
    chk("t4 pre timeout", int'(a_to), 0);
    step();
    chk("t4 timeout", int'(a_to), 1);
    chk("t4 latency", int'(a_lat), 16'hFFFF);
    chk("t4 index", int'(a_idx), 0);
    release_result();
    chk("t4 idle latency", int'(a_lat), 16'hFFFF);

    // Confirm on the timeout cycle wins; dut_b latency saturates at 7.
    start = 1'b1; ack = 1'b1; done = 8'h00;
    step();
    start = 1'b0; ack = 1'b0;
    for (int i = 1; i <= 8; i++) step();
    done = 8'h04;
    step();
    step();
    chk("t4b success", int'(a_succ), 1);
    chk("t4b timeout", int'(a_to), 0);
    chk("t4b latency", int'(a_lat), 10);
    step();
    chk("t7 b success", int'(b_succ), 1);
    chk("t7 b latency", int'(b_lat), 7);

    // ack+start in FOUND re-arms; start on a confirming cycle discards the confirm.
    done = 8'h10;
    start = 1'b1; ack = 1'b1;
    step();
    start = 1'b0; ack = 1'b0;
    chk("t5 rearm busy", int'(a_busy), 1);
    chk("t5 rearm success", int'(a_succ), 0);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5 restart success", int'(a_succ), 0);
    chk("t5 restart busy", int'(a_busy), 1);
    step();
    chk("t5 after restart", int'(a_succ), 0);
    step();
    chk("t5 late success", int'(a_succ), 1);
    chk("t5 late latency", int'(a_lat), 2);

    // Asynchronous reset mid-FOUND and mid-ARMED; 3-bit index 7.
    async_reset("t6 found");
    done = 8'h00;
    arm();
    async_reset("t6 armed");
    done = 8'h80;
    arm();
    step();
    step();
    chk("t6 index", int'(a_idx), 7);
    async_reset("t6 found7");
    repeat (3) step();
    chk("t6 no start busy", int'(a_busy), 0);
    chk("t6 no start success", int'(a_succ), 0);

    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 300 == 0) mode = int'($urandom_range(0, 2));
      if ($urandom_range(0, 499) == 0) begin
        start = 1'b0; ack = 1'b0;
        async_reset("rand reset");
      end else begin
        start = ($urandom_range(0, 19) == 0);
        ack   = ($urandom_range(0, 5) == 0);
        for (int i = 0; i < 8; i++) begin
          case (mode)
            0:       done[i] = ($urandom_range(0, 7) == 0);
            1:       if ($urandom_range(0, 7) == 0) done[i] = ~done[i];
            default: done[i] = ($urandom_range(0, 1) == 0);
          endcase
        end
        step();
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
